// File: rtl/data_mem_if.sv
// Request/response bundle between the load/store unit (master) and data_mem (slave).
// data_err is present only when DMEM_ERR_EN is defined.
interface data_mem_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4
);
  logic                       data_req;
  logic [DATA_WIDTH-1:0]      data_addr;
  logic                       data_we;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [BYTE_DATA_WIDTH-1:0] byte_enable;
  logic                       data_valid;
  logic [DATA_WIDTH-1:0]      rdata;
`ifdef DMEM_ERR_EN
  logic                       data_err;
`endif

  modport master (
    output data_req, data_addr, data_we, wdata, byte_enable,
`ifdef DMEM_ERR_EN
    input  data_err,
`endif
    input  data_valid, rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, wdata, byte_enable,
`ifdef DMEM_ERR_EN
    output data_err,
`endif
    output data_valid, rdata
  );
endinterface

// File: rtl/data_mem.sv
// Single-port word memory with byte-masked writes and WAIT_STATES extra cycles per access.
// Optional DMEM_ERR_EN adds range/alignment checking and the data_err response flag.
module data_mem #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int DEPTH_WORDS     = 1024,
  parameter int WAIT_STATES     = 1
) (
  input  logic      clk,
  input  logic      rst,
  data_mem_if.slave bus
);
  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
  logic                       we_q, we_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;

  logic                       commit_s;
  logic                       err_s;
  logic                       mem_we_s;
  logic                       unused_s;
  logic [DATA_WIDTH-1:0]      acc_addr_s;
  logic [DATA_WIDTH-1:0]      acc_wdata_s;
  logic [BYTE_DATA_WIDTH-1:0] acc_be_s;
  logic                       acc_we_s;
  logic [ADDR_BITS-1:0]       idx_s;

  logic [DATA_WIDTH-1:0]      mem [DEPTH_WORDS];

  // With zero wait states the access commits on the capture edge, so the live inputs are used.
  assign acc_addr_s  = (state_q == IDLE) ? bus.data_addr   : addr_q;
  assign acc_wdata_s = (state_q == IDLE) ? bus.wdata       : wdata_q;
  assign acc_be_s    = (state_q == IDLE) ? bus.byte_enable : be_q;
  assign acc_we_s    = (state_q == IDLE) ? bus.data_we     : we_q;
  assign idx_s       = acc_addr_s[ADDR_BITS+1:2];
  assign unused_s    = ^acc_addr_s;

`ifdef DMEM_ERR_EN
  localparam logic [DATA_WIDTH:0] ADDR_LIMIT = (DATA_WIDTH+1)'(DEPTH_WORDS * 4);

  assign err_s = ({1'b0, acc_addr_s} >= ADDR_LIMIT) ||
                 ((acc_addr_s[1:0] != 2'b00) && (acc_be_s != {BYTE_DATA_WIDTH{1'b0}}));
  assign bus.data_err = err_q;
`else
  assign err_s = 1'b0;
`endif

  assign mem_we_s       = commit_s && acc_we_s && !err_s;
  assign bus.data_valid = valid_q;
  assign bus.rdata      = rdata_q;

  // Next-state, capture and commit logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_req) begin
          addr_d  = bus.data_addr;
          wdata_d = bus.wdata;
          be_d    = bus.byte_enable;
          we_d    = bus.data_we;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            commit_s = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit_s = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response registers: valid/err pulse with the commit, rdata only changes on a read commit.
  always_comb begin
    valid_d = commit_s;
    err_d   = commit_s && err_s;
    rdata_d = rdata_q;
    if (commit_s && !acc_we_s) begin
      rdata_d = err_s ? {DATA_WIDTH{1'b0}} : mem[idx_s];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and response state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {DATA_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      be_q    <= {BYTE_DATA_WIDTH{1'b0}};
      we_q    <= 1'b0;
      rdata_q <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Storage array; not reset, and a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
        if (acc_be_s[i]) begin
          mem[idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: one instance with WAIT_STATES=1 and one with WAIT_STATES=0.
// Build with or without DMEM_ERR_EN; the aliasing test adapts to the macro.
module tb_data_mem;
  logic        clk;
  logic        rst;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        valid_s;
  logic [31:0] rdata_s;
  logic        err_s;
  logic [31:0] last_rdata;
  logic        last_err;
  int          vecs;
  int          miscompares;

  data_mem_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) if0 ();
  data_mem_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) if1 ();

  data_mem #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  data_mem #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  assign if0.data_req    = req & ~sel;
  assign if1.data_req    = req & sel;
  assign if0.data_addr   = addr;
  assign if1.data_addr   = addr;
  assign if0.data_we     = we;
  assign if1.data_we     = we;
  assign if0.wdata       = wd;
  assign if1.wdata       = wd;
  assign if0.byte_enable = be;
  assign if1.byte_enable = be;
  assign valid_s = sel ? if1.data_valid : if0.data_valid;
  assign rdata_s = sel ? if1.rdata : if0.rdata;
`ifdef DMEM_ERR_EN
  assign err_s = sel ? if1.data_err : if0.data_err;
`else
  assign err_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access with req held until data_valid; inputs are scrambled after the capture edge.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int lat);
    int cyc;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wd = d; be = b;
    @(posedge clk);
    #1;
    we = ~w; addr = ~a; wd = ~d; be = ~b;
    cyc = 0;
    while (valid_s !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    req = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0; be = 4'h0;
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    last_rdata = rdata_s;
    last_err   = err_s;
    @(posedge clk);
    #1;
    chk({tag, " valid one cycle"}, {31'd0, valid_s}, 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_pat;
    int         pulses;
    int         abort_valids;
    vecs = 0; miscompares = 0;
    sel = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0; be = 4'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid ws1", {31'd0, if1.data_valid}, 32'd0);
    chk("reset rdata ws1", if1.rdata, 32'h0);
    chk("reset valid ws0", {31'd0, if0.data_valid}, 32'd0);
    chk("reset rdata ws0", if0.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES=1: full write, read back, partial write, empty-mask write.
    sel = 1'b1;
    access("wr full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
    access("rd full", 1'b0, 32'h10, 32'h0, 4'h0, 1);
    chk("rd full data", last_rdata, 32'hDEADBEEF);
    access("wr lane0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1);
    chk("rdata held over write", last_rdata, 32'hDEADBEEF);
    access("rd lane0", 1'b0, 32'h10, 32'h0, 4'h0, 1);
    chk("rd lane0 data", last_rdata, 32'hDEADBEAA);
    access("wr nomask", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1);
    access("rd nomask", 1'b0, 32'h10, 32'h0, 4'h0, 1);
    chk("rd nomask data", last_rdata, 32'hDEADBEAA);

    // WAIT_STATES=0: back-to-back reads with req held high.
    sel = 1'b0;
    access("ws0 wr", 1'b1, 32'h0, 32'h11111111, 4'hF, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0;
    @(posedge clk);
    pat = 8'h00;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      pat[i] = valid_s;
      if (valid_s === 1'b1) begin
        pulses++;
        chk("ws0 held rdata", rdata_s, 32'h11111111);
      end
      if (pulses == 3) req = 1'b0;
      @(posedge clk);
    end
    req = 1'b0;
    exp_pat = 8'b0001_0101;
    chk("ws0 valid pattern", {24'd0, pat}, {24'd0, exp_pat});
    chk("ws0 pulse count", 32'(pulses), 32'd3);

    // Reset during the wait state of a write aborts it.
    sel = 1'b1;
    access("wr base", 1'b1, 32'h20, 32'h12345678, 4'hF, 1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort valid", {31'd0, if1.data_valid}, 32'd0);
    chk("abort rdata", if1.rdata, 32'h0);
    chk("abort err", {31'd0, err_s}, 32'd0);
    abort_valids = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (if1.data_valid !== 1'b0) abort_valids++;
    end
    chk("abort no valid", 32'(abort_valids), 32'd0);
    @(negedge clk);
    req = 1'b0; rst = 1'b0;
    access("rd after abort", 1'b0, 32'h20, 32'h0, 4'h0, 1);
    chk("rd after abort data", last_rdata, 32'h12345678);

    // Out-of-range address: aliases by default, flagged with DMEM_ERR_EN.
    access("wr zero", 1'b1, 32'h0, 32'h00000055, 4'hF, 1);
    access("rd alias", 1'b0, 32'h1000, 32'h0, 4'h0, 1);
`ifdef DMEM_ERR_EN
    chk("alias err", {31'd0, last_err}, 32'd1);
    chk("alias rdata", last_rdata, 32'h0);
    access("rd zero", 1'b0, 32'h0, 32'h0, 4'h0, 1);
    chk("next err", {31'd0, last_err}, 32'd0);
    chk("next rdata", last_rdata, 32'h00000055);
`else
    chk("alias rdata", last_rdata, 32'h00000055);
    chk("alias err", {31'd0, last_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem.md
# data_mem

Single-port, word-organised data memory with a configurable number of wait states. It sits directly downstream of the load/store unit on the data-cache interface. It accepts one request at a time over a req/valid handshake and returns read data or write completion after a fixed latency. Writes are masked per byte; reads always return a full word.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- BYTE_DATA_WIDTH, 4, byte-lane count (DATA_WIDTH/8)
- DEPTH_WORDS, 1024, memory depth in words, power of two; ADDR_BITS = $clog2(DEPTH_WORDS)
- WAIT_STATES, 1, extra cycles per access, 0..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- data_req  in  1  request, held high by requester until data_valid
- data_addr  in  DATA_WIDTH  byte address
- data_we  in  1  1 = write, 0 = read
- wdata  in  DATA_WIDTH  write data
- byte_enable  in  BYTE_DATA_WIDTH  write lane mask, bit i covers wdata[8i+7:8i]
- data_valid  out  1  one-cycle completion strobe
- rdata  out  DATA_WIDTH  read data, registered
- data_err  out  1  access error, present only with DMEM_ERR_EN

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: data_req=1 at an edge captures the address, data_we, wdata and byte_enable into internal registers. The wait counter loads WAIT_STATES. Next state is WAIT, or RESP if WAIT_STATES==0.
- WAIT: the counter decrements each cycle. The edge at which it reaches 0 commits the access and moves to RESP.
- Commit edge, read: rdata <= mem[word index].
- Commit edge, write: mem[word index] lane i <= wdata lane i for every set byte_enable bit. rdata is unchanged.
- RESP: data_valid=1 for exactly one cycle, then unconditional return to IDLE.
- data_req seen in WAIT or RESP belongs to the current access and is ignored. New requests are sampled only in IDLE.
- Word index = data_addr[ADDR_BITS+1:2]. data_addr[1:0] is ignored; alignment is the LSU's responsibility.
- Upper address bits are ignored, so out-of-range addresses alias.
- A write with byte_enable=0 completes normally and leaves memory unchanged.
- rdata holds its last read value through writes and idle cycles.
- Input changes after the capture edge have no effect on the access in flight.

## Timing
- Reset values: state IDLE, counter 0, data_valid 0, rdata 0, data_err 0. Memory contents are not reset.
- Latency: data_req sampled at edge E; data_valid is high in the cycle following edge E+WAIT_STATES+1 minus one, i.e. WAIT_STATES+1 cycles after E.
- Throughput: one access per WAIT_STATES+2 cycles when data_req is held continuously.
- Reset asserted mid-access aborts immediately: no data_valid is produced.
- A write aborted before its commit edge does not modify memory.
- Reset asserted in the same cycle as the commit edge takes priority; no commit occurs.

## Configuration
- Macro: DMEM_ERR_EN.
- Defined:
  - data_err port exists.
  - An access is erroneous if data_addr >= DEPTH_WORDS*4, or if data_addr[1:0] != 0 while any byte_enable bit is set.
  - An erroneous access still completes with normal latency, with data_err=1 in the data_valid cycle only.
  - Erroneous writes do not modify memory.
  - Erroneous reads load rdata with 0.
- Undefined: no data_err port; addresses alias and low bits are ignored, as described in Operation.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to 0x10 with byte_enable=4'hF, then read 0x10 -> each data_valid arrives 2 cycles after the capture edge; read returns rdata=0xDEADBEEF.
- Write 0x000000AA to 0x10 with byte_enable=4'b0001, then read 0x10 -> rdata=0xDEADBEAA. Then write 0xFFFFFFFF with byte_enable=0 -> data_valid pulses; a subsequent read still returns 0xDEADBEAA.
- WAIT_STATES=0: data_req held high for 3 reads -> data_valid in cycles 1, 3, 5 after the first capture edge; exactly 3 pulses.
- Write 0x12345678 to 0x20, then write 0xCAFEF00D to 0x20 and assert rst during WAIT -> no data_valid; after reset, read 0x20 returns 0x12345678; all outputs are 0 during reset.
- DEPTH_WORDS=1024, write 0x55 to 0x0 then read 0x1000 -> without DMEM_ERR_EN, rdata=0x55 (aliased). With DMEM_ERR_EN, data_err=1 with data_valid and rdata=0; data_err is 0 on the next valid access.
